mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (port I) and the load/store requester (port D).
- Sits between the fetch/LSU stages and a unified memory.
- Round-robin arbitration; exactly one outstanding transaction.
- A response watchdog closes hung transactions with an error.
- The core's stall logic consumes busy_o and the per-port grant/valid strobes.

Parameters:
DW, 32, data width
AW, 32, address width
MW, 4, byte-mask width (DW/8)
TIMEOUT, 255, max cycles waiting for mem_rvalid_i before error completion (1..2^16-1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; asynchronous, active-high
i_req_i  in  1  fetch request, held until i_gnt_o
i_addr_i  in  AW  fetch address
i_gnt_o  out  1  fetch request accepted (1-cycle pulse)
i_rvalid_o  out  1  fetch data valid (1-cycle pulse)
i_rdata_o  out  DW  fetch data
i_err_o  out  1  fetch completed by timeout (with i_rvalid_o)
d_req_i  in  1  data request, held until d_gnt_o
d_we_i  in  1  1=store, 0=load
d_mask_i  in  MW  byte enables
d_addr_i  in  AW  data address
d_wdata_i  in  DW  store data
d_gnt_o  out  1  data request accepted
d_rvalid_o  out  1  load data / store ack valid
d_rdata_o  out  DW  load data
d_err_o  out  1  data completed by timeout
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_mask_o  out  MW  memory byte enables
mem_addr_o  out  AW  memory address
mem_wdata_o  out  DW  memory write data
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  memory response (reads and writes)
mem_rdata_i  in  DW  memory read data
busy_o  out  1  state != IDLE
spurious_o  out  1  sticky: mem_rvalid_i seen outside WAIT

Behaviour:
- Reset: rst_i asserted (async) forces:
  - state=IDLE, owner=I, last=I;
  - all mem_* outputs 0, all *_gnt/*_rvalid/*_err 0;
  - timer 0, spurious_o 0.
- Reset mid-transaction discards the transaction and any late response; requesters re-issue.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any req_i is high, select a winner.
    - Both requesting: the port not equal to last wins. last resets to I, so D wins the first tie.
    - Single requester: that requester wins.
  - At the clock edge, register winner's addr/we/mask/wdata into the mem_* outputs; owner=winner; go to REQ.
  - Port I always registers we=0, mask all-ones, wdata 0.
- REQ:
  - mem_req_o=1; mem_* outputs stable.
  - When mem_gnt_i=1: owner's gnt_o=1 combinationally that cycle; last<=owner; timer<=0; go to WAIT; mem_req_o deasserts from the next cycle.
  - A requester dropping req_i before its grant is illegal; the arbiter still completes the transaction.
- WAIT:
  - Timer increments each cycle.
  - If mem_rvalid_i=1: owner's rvalid_o=1 and rdata_o=mem_rdata_i combinationally; go to IDLE.
  - Else, if timer==TIMEOUT-1: owner's rvalid_o=1, err_o=1, rdata_o=0; go to IDLE.
  - If rvalid and timeout coincide, rvalid wins with err_o=0.
- Non-owner port: gnt/rvalid/err held 0 and rdata held 0 at all times. Owner rdata is 0 outside an rvalid cycle.
- Minimum latency, request to rvalid: 3 cycles. Sequence: req seen in IDLE at edge 0; REQ with mem_gnt_i same cycle; WAIT with mem_rvalid_i → rvalid in cycle 2.
- Back-to-back: a new arbitration occurs only in the IDLE cycle after completion. There is one idle bubble per transaction.
- mem_rvalid_i while in IDLE or REQ: ignored and not forwarded; sets spurious_o, which stays set until reset.
- Simultaneous req arrival while busy: requesters wait; no queueing beyond the held req_i.
- busy_o is registered-state derived; it is 1 in REQ and WAIT.

Test Plan:
- Single fetch, no contention:
  - Stimulus: i_req_i=1, i_addr_i=0x0000_0010; memory grants immediately, returns 0xDEAD_BEEF next cycle.
  - Response: mem_addr_o=0x10, mem_we_o=0, mem_mask_o=0xF; i_gnt_o pulse in cycle 1; i_rvalid_o with 0xDEAD_BEEF in cycle 2; d_* outputs stay 0.
- Tie after reset:
  - Stimulus: i_req_i and d_req_i both high from cycle 0, d_we_i=1, d_addr_i=0x80, d_wdata_i=0x1234_5678, d_mask_i=0x3.
  - Response: D served first with mem_we_o=1, mem_mask_o=0x3, mem_wdata_o=0x1234_5678; I served next. Continuous requests alternate D,I,D,I.
- Grant stall:
  - Stimulus: mem_gnt_i held low 4 cycles.
  - Response: mem_req_o high and mem_addr_o unchanged for 5 cycles; gnt_o only in the cycle mem_gnt_i=1.
- Timeout:
  - Stimulus: TIMEOUT=8, mem_rvalid_i never asserted after grant.
  - Response: owner rvalid_o=1, err_o=1, rdata_o=0 exactly 8 cycles after the grant cycle; busy_o=0 next cycle.
  - Stimulus variant: rvalid arriving in the timeout cycle.
  - Response: err_o=0.
- Spurious and reset:
  - Stimulus: mem_rvalid_i pulse in IDLE.
  - Response: spurious_o=1, no rvalid_o.
  - Stimulus: assert rst_i asynchronously mid-WAIT.
  - Response: all outputs 0 immediately, state IDLE; a late mem_rvalid_i after reset release sets spurious_o and is not forwarded.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/load-store arbiter onto one single-port memory
// One outstanding transaction at a time; a watchdog closes hung responses with an error.
module mem_port_arbiter #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int MW      = 4,
   parameter int TIMEOUT = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          i_req_i,
   input  logic [AW-1:0] i_addr_i,
   output logic          i_gnt_o,
   output logic          i_rvalid_o,
   output logic [DW-1:0] i_rdata_o,
   output logic          i_err_o,
   input  logic          d_req_i,
   input  logic          d_we_i,
   input  logic [MW-1:0] d_mask_i,
   input  logic [AW-1:0] d_addr_i,
   input  logic [DW-1:0] d_wdata_i,
   output logic          d_gnt_o,
   output logic          d_rvalid_o,
   output logic [DW-1:0] d_rdata_o,
   output logic          d_err_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [MW-1:0] mem_mask_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic          mem_gnt_i,
   input  logic          mem_rvalid_i,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          busy_o,
   output logic          spurious_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   state_t      state_q, state_d;
   logic        owner_q;
   logic        last_q;
   logic        winner;
   logic        any_req;
   logic [15:0] timer_q;
   logic        timeout_hit;
   logic        done;

   assign any_req     = i_req_i | d_req_i;
   // On a tie the port that was not served last wins; last starts at I so D takes the first tie.
   assign winner      = (i_req_i && d_req_i) ? ~last_q : d_req_i;
   assign timeout_hit = (timer_q == 16'(TIMEOUT - 1));
   assign done        = (state_q == WAIT) && (mem_rvalid_i || timeout_hit);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req)   state_d = REQ;
         REQ:     if (mem_gnt_i) state_d = WAIT;
         WAIT:    if (done)      state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner_q     <= PORT_I;
         last_q      <= PORT_I;
         timer_q     <= '0;
         mem_we_o    <= 1'b0;
         mem_mask_o  <= '0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         spurious_o  <= 1'b0;
      end else begin
         if (state_q == IDLE && any_req) begin
            owner_q <= winner;
            if (winner == PORT_D) begin
               mem_we_o    <= d_we_i;
               mem_mask_o  <= d_mask_i;
               mem_addr_o  <= d_addr_i;
               mem_wdata_o <= d_wdata_i;
            end else begin
               mem_we_o    <= 1'b0;
               mem_mask_o  <= '1;
               mem_addr_o  <= i_addr_i;
               mem_wdata_o <= '0;
            end
         end
         if (state_q == REQ && mem_gnt_i) begin
            last_q  <= owner_q;
            timer_q <= '0;
         end else if (state_q == WAIT) begin
            timer_q <= timer_q + 16'd1;
         end
         // A response with no transaction in flight is never forwarded, only flagged.
         if (mem_rvalid_i && state_q != WAIT) begin
            spurious_o <= 1'b1;
         end
      end
   end

   always_comb begin
      mem_req_o  = (state_q == REQ);
      busy_o     = (state_q != IDLE);
      i_gnt_o    = 1'b0;
      d_gnt_o    = 1'b0;
      i_rvalid_o = 1'b0;
      d_rvalid_o = 1'b0;
      i_err_o    = 1'b0;
      d_err_o    = 1'b0;
      i_rdata_o  = '0;
      d_rdata_o  = '0;
      if (state_q == REQ && mem_gnt_i) begin
         if (owner_q == PORT_D) d_gnt_o = 1'b1;
         else                   i_gnt_o = 1'b1;
      end
      if (done) begin
         if (owner_q == PORT_D) begin
            d_rvalid_o = 1'b1;
            d_err_o    = ~mem_rvalid_i;
            d_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
         end else begin
            i_rvalid_o = 1'b1;
            i_err_o    = ~mem_rvalid_i;
            i_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MW = 4;
   localparam int TO = 8;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          i_req_i = 1'b0;
   logic [AW-1:0] i_addr_i = '0;
   logic          i_gnt_o, i_rvalid_o, i_err_o;
   logic [DW-1:0] i_rdata_o;
   logic          d_req_i = 1'b0;
   logic          d_we_i = 1'b0;
   logic [MW-1:0] d_mask_i = '0;
   logic [AW-1:0] d_addr_i = '0;
   logic [DW-1:0] d_wdata_i = '0;
   logic          d_gnt_o, d_rvalid_o, d_err_o;
   logic [DW-1:0] d_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [MW-1:0] mem_mask_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_gnt_i = 1'b0;
   logic          mem_rvalid_i = 1'b0;
   logic [DW-1:0] mem_rdata_i = '0;
   logic          busy_o, spurious_o;

   mem_port_arbiter #(.DW(DW), .AW(AW), .MW(MW), .TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
      .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_mask_i(d_mask_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
      .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_mask_o(mem_mask_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .spurious_o(spurious_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          cyc;
      bit          port;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  mask;
      logic [31:0] wdata;
   } gnt_t;

   typedef struct {
      int          cyc;
      bit          port;
      logic [31:0] data;
      bit          err;
   } rsp_t;

   gnt_t gq[$];
   rsp_t rq[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   chk_en = 1'b0;
   bit   exp_busy = 1'b0;
   bit   exp_req = 1'b0;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   always @(negedge clk_i) begin : monitor
      gnt_t g;
      rsp_t r;
      if (gq.size() > 0 && gq[0].cyc < cyc) begin
         g = gq.pop_front();
         check_eq("gnt_missing", 32'(cyc), 32'(g.cyc));
      end
      if (rq.size() > 0 && rq[0].cyc < cyc) begin
         r = rq.pop_front();
         check_eq("rvalid_missing", 32'(cyc), 32'(r.cyc));
      end
      if (i_gnt_o || d_gnt_o) begin
         if (gq.size() == 0) begin
            check_eq("gnt_unexpected", {30'd0, d_gnt_o, i_gnt_o}, 32'd0);
         end else begin
            g = gq.pop_front();
            check_eq("gnt_port", {30'd0, d_gnt_o, i_gnt_o}, g.port ? 32'd2 : 32'd1);
            check_eq("gnt_cycle", 32'(cyc), 32'(g.cyc));
            check_eq("mem_req_at_gnt", {31'd0, mem_req_o}, 32'd1);
            check_eq("mem_addr", mem_addr_o, g.addr);
            check_eq("mem_we", {31'd0, mem_we_o}, {31'd0, g.we});
            check_eq("mem_mask", {28'd0, mem_mask_o}, {28'd0, g.mask});
            check_eq("mem_wdata", mem_wdata_o, g.wdata);
         end
      end
      if (i_rvalid_o || d_rvalid_o) begin
         if (rq.size() == 0) begin
            check_eq("rvalid_unexpected", {30'd0, d_rvalid_o, i_rvalid_o}, 32'd0);
         end else begin
            r = rq.pop_front();
            check_eq("rvalid_port", {30'd0, d_rvalid_o, i_rvalid_o}, r.port ? 32'd2 : 32'd1);
            check_eq("rvalid_cycle", 32'(cyc), 32'(r.cyc));
            check_eq("rdata", r.port ? d_rdata_o : i_rdata_o, r.data);
            check_eq("err", {31'd0, r.port ? d_err_o : i_err_o}, {31'd0, r.err});
            check_eq("other_rdata", r.port ? i_rdata_o : d_rdata_o, 32'd0);
         end
      end
      if (chk_en) begin
         check_eq("busy", {31'd0, busy_o}, {31'd0, exp_busy});
         check_eq("mem_req", {31'd0, mem_req_o}, {31'd0, exp_req});
         if (!i_rvalid_o) check_eq("i_quiet", {i_rdata_o[31:1], i_rdata_o[0] | i_err_o}, 32'd0);
         if (!d_rvalid_o) check_eq("d_quiet", {d_rdata_o[31:1], d_rdata_o[0] | d_err_o}, 32'd0);
      end
   end

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ctrl"}, {18'd0, i_gnt_o, i_rvalid_o, i_err_o, d_gnt_o, d_rvalid_o, d_err_o,
                               mem_req_o, mem_we_o, busy_o, spurious_o, mem_mask_o}, 32'd0);
      check_eq({tag, "_addr"}, mem_addr_o, 32'd0);
      check_eq({tag, "_wdata"}, mem_wdata_o, 32'd0);
      check_eq({tag, "_rdata"}, i_rdata_o | d_rdata_o, 32'd0);
   endtask

   initial begin : driver
      bit          pend_i, pend_d, last, win;
      int          idle_c, cur_e, cur_g, drop_k, sched_g, sched_rv;
      int          gd, rd, c, r, n, ntx;
      logic [31:0] rv_data;
      gnt_t        g;
      rsp_t        x;
      pend_i = 0; pend_d = 0; last = 0; win = 0;
      idle_c = 0; cur_e = -10; cur_g = -10; drop_k = -1; sched_g = -1; sched_rv = -1;
      n = 0; ntx = 0; rv_data = '0;

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_all_zero("reset");
      rst_i = 1'b0;
      tick();
      chk_en = 1'b1;

      // Randomized phase: requesters hold req until their scheduled grant; memory timing is chosen per transaction.
      while ((n < 3000 || pend_i || pend_d || cyc <= idle_c) && n < 10000) begin
         tick();
         if (cyc == drop_k) begin
            if (win) begin pend_d = 0; d_req_i = 1'b0; end
            else     begin pend_i = 0; i_req_i = 1'b0; end
         end
         if (n == 0) begin
            pend_i = 1; i_req_i = 1'b1; i_addr_i = 32'h0000_0010;
            pend_d = 1; d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h80;
            d_wdata_i = 32'h1234_5678; d_mask_i = 4'h3;
         end else if (n < 3000) begin
            if (!pend_i && $urandom_range(0, 3) == 0) begin
               pend_i = 1; i_req_i = 1'b1; i_addr_i = $urandom;
            end
            if (!pend_d && $urandom_range(0, 3) == 0) begin
               pend_d = 1; d_req_i = 1'b1; d_we_i = 1'($urandom);
               d_mask_i = 4'($urandom); d_addr_i = $urandom; d_wdata_i = $urandom;
            end
         end
         if (cyc >= idle_c && (pend_i || pend_d)) begin
            win  = (pend_i && pend_d) ? !last : pend_d;
            last = win;
            r = $urandom_range(0, 9);
            if (r < 6)       rd = r % 4;
            else if (r == 6) rd = TO - 1;
            else             rd = TO + r - 7;
            gd = $urandom_range(0, 4);
            rv_data = $urandom;
            if (ntx < 2) begin gd = 0; rd = 0; end
            if (ntx == 1) rv_data = 32'hDEAD_BEEF;
            ntx++;
            c        = (rd < TO) ? rd : TO - 1;
            cur_e    = cyc + 1;
            cur_g    = cur_e + gd;
            sched_g  = cur_g;
            drop_k   = cur_g + 1;
            sched_rv = (rd < TO) ? cur_g + 1 + rd : -1;
            idle_c   = cur_g + 2 + c;
            g.cyc  = cur_g;
            g.port = win;
            g.addr  = win ? d_addr_i : i_addr_i;
            g.we    = win ? d_we_i : 1'b0;
            g.mask  = win ? d_mask_i : 4'hF;
            g.wdata = win ? d_wdata_i : 32'd0;
            gq.push_back(g);
            x.cyc  = cur_g + 1 + c;
            x.port = win;
            x.err  = (rd >= TO);
            x.data = x.err ? 32'd0 : rv_data;
            rq.push_back(x);
         end
         mem_gnt_i    = (cyc == sched_g);
         mem_rvalid_i = (cyc == sched_rv);
         mem_rdata_i  = (cyc == sched_rv) ? rv_data : $urandom;
         exp_busy     = (cyc >= cur_e) && (cyc < idle_c);
         exp_req      = (cyc >= cur_e) && (cyc <= cur_g);
         n++;
      end
      tick();
      chk_en = 1'b0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      check_eq("gnt_queue_drained", 32'(gq.size()), 32'd0);
      check_eq("rsp_queue_drained", 32'(rq.size()), 32'd0);
      check_eq("spurious_before", {31'd0, spurious_o}, 32'd0);

      // Response while idle: flagged, not forwarded.
      tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
      @(negedge clk_i);
      check_eq("spur_no_rvalid", {30'd0, d_rvalid_o, i_rvalid_o}, 32'd0);
      tick();
      mem_rvalid_i = 1'b0;
      check_eq("spurious_set", {31'd0, spurious_o}, 32'd1);

      // Asynchronous reset in WAIT discards the transaction and its late response.
      i_req_i = 1'b1; i_addr_i = 32'h44;
      tick();
      mem_gnt_i = 1'b1;
      g.cyc = cyc; g.port = 1'b0; g.addr = 32'h44; g.we = 1'b0; g.mask = 4'hF; g.wdata = 32'd0;
      gq.push_back(g);
      tick();
      mem_gnt_i = 1'b0; i_req_i = 1'b0;
      tick();
      check_eq("busy_in_wait", {31'd0, busy_o}, 32'd1);
      #2 rst_i = 1'b1;
      #1 check_all_zero("async_reset");
      tick();
      #2 rst_i = 1'b0;
      tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
      @(negedge clk_i);
      check_eq("late_no_rvalid", {30'd0, d_rvalid_o, i_rvalid_o}, 32'd0);
      tick();
      mem_rvalid_i = 1'b0;
      check_eq("late_spurious", {31'd0, spurious_o}, 32'd1);
      check_eq("late_busy", {31'd0, busy_o}, 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
